// File: rtl/stall_flush_unit.sv
// Stall/flush hazard unit: holds F/D or bubbles E when a needed result is not ready
// (load-use, long-latency scoreboard hit, or long-op capacity full), and flushes D/E on a taken branch.
module stall_flush_unit #(
  parameter int MAX_OUT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        RS1D,
  input  logic [4:0]        RS2D,
  input  logic [4:0]        RDD,
  input  logic              RegWriteD,
  input  logic              LongD,
  input  logic [4:0]        RDE,
  input  logic              RegWriteE,
  input  logic              LoadE,
  input  logic              IssueLongE,
  input  logic              LongDone,
  input  logic [4:0]        LongRd,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [31:0]       Pending,
  output logic [PERF_W-1:0] StallCnt,
  output logic              SbErr
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  logic [31:0]       pending_q, pending_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              sb_err_q, sb_err_d;

  logic lduse, sbhaz, fullhaz, stall;

  assign lduse = LoadE && RegWriteE && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));
  // Registered Pending only: a writeback this cycle still stalls; the regfile has it next cycle.
  assign sbhaz = ((RS1D != 5'd0) && pending_q[RS1D]) ||
                 ((RS2D != 5'd0) && pending_q[RS2D]) ||
                 (RegWriteD && (RDD != 5'd0) && pending_q[RDD]);
  assign fullhaz = LongD && (count_q == MAX_C);
  assign stall   = lduse || sbhaz || fullhaz;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!reset) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = stall;
        StallD = stall;
        FlushE = stall;
      end
    end
  end

  // Set beats clear on the same register: the newly issued op is the one in flight.
  assign pending_d[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_pend
    always_comb begin
      pending_d[gi] = pending_q[gi];
      if (IssueLongE && (RDE == 5'(gi)))
        pending_d[gi] = 1'b1;
      else if (LongDone && (LongRd == 5'(gi)))
        pending_d[gi] = 1'b0;
    end
  end

  always_comb begin
    count_d  = count_q;
    sb_err_d = sb_err_q || (LongDone && (count_q == '0));
    if (IssueLongE && !LongDone) begin
      if (count_q != MAX_C)
        count_d = count_q + 1'b1;
    end else if (!IssueLongE && LongDone) begin
      if (count_q != '0)
        count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign Pending  = pending_q;
  assign StallCnt = stall_cnt_q;
  assign SbErr    = sb_err_q;

endmodule

// File: tb/tb_stall_flush_unit.sv
// Bench for stall_flush_unit: a vector table plus hand sequences, with expected
// control outputs queued when driven and compared at the following negedge.
module tb_stall_flush_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RS1D, RS2D, RDD, RDE, LongRd;
  logic        RegWriteD, LongD, RegWriteE, LoadE, IssueLongE, LongDone, PCSrcE;
  logic        StallF, StallD, FlushD, FlushE, SbErr;
  logic [31:0] Pending;
  logic [15:0] StallCnt;

  stall_flush_unit #(.MAX_OUT(4), .PERF_W(16)) dut (
    .clk(clk), .reset(reset),
    .RS1D(RS1D), .RS2D(RS2D), .RDD(RDD), .RegWriteD(RegWriteD), .LongD(LongD),
    .RDE(RDE), .RegWriteE(RegWriteE), .LoadE(LoadE), .IssueLongE(IssueLongE),
    .LongDone(LongDone), .LongRd(LongRd), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Pending(Pending), .StallCnt(StallCnt), .SbErr(SbErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rdd;
    logic       regwd, longd;
    logic [4:0] rde;
    logic       regwe, loade, issue, done;
    logic [4:0] longrd;
    logic       pcsrc, stall;
    string      nm;
  } vec_t;

  typedef struct {
    logic  sf, sd, fd, fe;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   model_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t zv(input string nm);
    vec_t v;
    v.rs1 = 0; v.rs2 = 0; v.rdd = 0; v.regwd = 0; v.longd = 0;
    v.rde = 0; v.regwe = 0; v.loade = 0; v.issue = 0; v.done = 0;
    v.longrd = 0; v.pcsrc = 0; v.stall = 0; v.nm = nm;
    return v;
  endfunction

  function automatic vec_t ld(input string nm, input logic [4:0] rde, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic regwe, input logic loade,
                              input logic pcsrc, input logic stall);
    vec_t v = zv(nm);
    v.rde = rde; v.rs1 = rs1; v.rs2 = rs2; v.regwe = regwe; v.loade = loade;
    v.pcsrc = pcsrc; v.stall = stall;
    return v;
  endfunction

  function automatic vec_t iss(input string nm, input logic [4:0] rd);
    vec_t v = zv(nm);
    v.issue = 1; v.regwe = 1; v.rde = rd;
    return v;
  endfunction

  function automatic vec_t dn(input string nm, input logic [4:0] rd);
    vec_t v = zv(nm);
    v.done = 1; v.longrd = rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RS1D = v.rs1; RS2D = v.rs2; RDD = v.rdd; RegWriteD = v.regwd; LongD = v.longd;
    RDE = v.rde; RegWriteE = v.regwe; LoadE = v.loade; IssueLongE = v.issue;
    LongDone = v.done; LongRd = v.longrd; PCSrcE = v.pcsrc;
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input vec_t v);
    exp_t e, g;
    drive(v);
    e.fd = v.pcsrc;
    e.fe = v.pcsrc | v.stall;
    e.sf = !v.pcsrc & v.stall;
    e.sd = !v.pcsrc & v.stall;
    e.nm = v.nm;
    sbq.push_back(e);
    @(negedge clk);
    g = sbq.pop_front();
    chk({g.nm, ".StallF"}, 32'(StallF), 32'(g.sf));
    chk({g.nm, ".StallD"}, 32'(StallD), 32'(g.sd));
    chk({g.nm, ".FlushD"}, 32'(FlushD), 32'(g.fd));
    chk({g.nm, ".FlushE"}, 32'(FlushE), 32'(g.fe));
    $display("step %-14s sf=%b sd=%b fd=%b fe=%b pend=%08h", g.nm, StallF, StallD, FlushD, FlushE, Pending);
    if (g.sd) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;

    tbl[0] = ld("idle",        5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tbl[1] = ld("lduse_rs1",   5'd5, 5'd5, 5'd0, 1, 1, 0, 1);
    tbl[2] = ld("after_lduse", 5'd0, 5'd5, 5'd0, 0, 0, 0, 0);
    tbl[3] = ld("lduse_rs2",   5'd6, 5'd1, 5'd6, 1, 1, 0, 1);
    tbl[4] = ld("load_r0",     5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    tbl[5] = ld("load_nowr",   5'd5, 5'd5, 5'd0, 0, 1, 0, 0);
    tbl[6] = ld("alu_match",   5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
    tbl[7] = ld("load_nomatch",5'd5, 5'd6, 5'd7, 1, 1, 0, 0);
    tbl[8] = ld("lduse_branch",5'd5, 5'd5, 5'd5, 1, 1, 1, 0);
    tbl[9] = ld("branch",      5'd0, 5'd0, 5'd0, 0, 0, 1, 0);

    // Reset held: outputs gated even with a load-use and a branch present.
    reset = 1'b1;
    drive(ld("rst", 5'd5, 5'd5, 5'd0, 1, 1, 0, 0));
    #3;
    chk("rst.StallD", 32'(StallD), 32'd0);
    chk("rst.FlushE", 32'(FlushE), 32'd0);
    PCSrcE = 1'b1;
    #1;
    chk("rst.FlushD", 32'(FlushD), 32'd0);
    chk("rst.Pending", Pending, 32'd0);
    chk("rst.StallCnt", 32'(StallCnt), 32'd0);
    chk("rst.SbErr", 32'(SbErr), 32'd0);
    #8;
    reset = 1'b0;
    drive(zv("idle"));
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) step(tbl[i]);
    chk("table.StallCnt", 32'(StallCnt), 32'(model_cnt));

    // Scoreboard hold and release one cycle after LongDone.
    step(iss("iss7", 5'd7));
    chk("iss7.Pending", Pending, 32'h0000_0080);
    v = zv("use7_a"); v.rs2 = 7; v.stall = 1; step(v);
    v.nm = "use7_b"; step(v);
    v.nm = "use7_done"; v.done = 1; v.longrd = 7; step(v);
    v = zv("use7_free"); v.rs2 = 7; step(v);
    chk("done7.Pending", Pending, 32'd0);
    chk("seq2.StallCnt", 32'(StallCnt), 32'(model_cnt));

    // Set/clear collision and WAW.
    step(iss("iss9", 5'd9));
    v = iss("coll9", 5'd9); v.done = 1; v.longrd = 9; step(v);
    chk("coll9.Pending", Pending, 32'h0000_0200);
    v = zv("waw9"); v.rdd = 9; v.regwd = 1; v.stall = 1; step(v);
    v = zv("waw9_nowr"); v.rdd = 9; step(v);
    step(dn("done9", 5'd9));
    chk("done9.Pending", Pending, 32'd0);
    chk("done9.SbErr", 32'(SbErr), 32'd0);

    // Capacity full, then an extra LongDone.
    for (int r = 1; r <= 4; r++) step(iss("iss_full", 5'(r)));
    chk("full.Pending", Pending, 32'h0000_001E);
    v = zv("full_a"); v.longd = 1; v.rs1 = 10; v.rs2 = 10; v.stall = 1; step(v);
    v.nm = "full_b"; step(v);
    v.nm = "full_done"; v.done = 1; v.longrd = 1; step(v);
    v = zv("full_free"); v.longd = 1; v.rs1 = 10; v.rs2 = 10; step(v);
    for (int r = 2; r <= 4; r++) step(dn("drain", 5'(r)));
    chk("drain.SbErr", 32'(SbErr), 32'd0);
    step(dn("extra_done", 5'd5));
    chk("extra.SbErr", 32'(SbErr), 32'd1);
    step(zv("idle"));
    chk("sticky.SbErr", 32'(SbErr), 32'd1);
    chk("seq5.StallCnt", 32'(StallCnt), 32'(model_cnt));

    // Reset mid-operation: Pending=0xF00, count=3.
    for (int r = 8; r <= 11; r++) step(iss("iss_mid", 5'(r)));
    step(dn("done_r0", 5'd0));
    chk("mid.Pending", Pending, 32'h0000_0F00);
    v = zv("mid"); v.rs1 = 8; drive(v);
    #2;
    chk("mid.StallD", 32'(StallD), 32'd1);
    reset = 1'b1;
    PCSrcE = 1'b1;
    #1;
    chk("async.StallF", 32'(StallF), 32'd0);
    chk("async.FlushD", 32'(FlushD), 32'd0);
    chk("async.Pending", Pending, 32'd0);
    chk("async.StallCnt", 32'(StallCnt), 32'd0);
    chk("async.SbErr", 32'(SbErr), 32'd0);
    model_cnt = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    v = zv("post_rst"); v.rs1 = 8; v.longd = 1; drive(v);
    #1;
    chk("post_rst.StallD", 32'(StallD), 32'd0);
    @(posedge clk);
    #1;
    step(v);
    chk("post_rst.Pending", Pending, 32'd0);
    chk("post_rst.StallCnt", 32'(StallCnt), 32'(model_cnt));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
